// File: rtl/barrel_shifter_pipe.sv
// Pipelined shift/rotate unit: one register stage per shift-amount bit.
// Stage k applies a shift of 2^k when bit k of the carried shift amount is set.
// Modes: ROL, ROR, SHL (zero fill), ASR (fill with the operand's original sign).
// All stages advance together under a single stall signal, and bubbles are kept.
module barrel_shifter_pipe #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shift,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    typedef enum logic [1:0] {
        MODE_ROL = 2'b00,
        MODE_ROR = 2'b01,
        MODE_SHL = 2'b10,
        MODE_ASR = 2'b11
    } mode_e;

    // Fixed-distance shift used by one stage. At every call site, amt is a
    // constant 2^k.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input mode_e            mode,
        input logic             sign,
        input int               amt
    );
        logic [WIDTH-1:0] fill;
        // Ones in the top amt bit positions when the carried sign is set.
        fill = ~({WIDTH{1'b1}} >> amt) & {WIDTH{sign}};
        case (mode)
            MODE_ROL: shift_step = (d << amt) | (d >> (WIDTH - amt));
            MODE_ROR: shift_step = (d >> amt) | (d << (WIDTH - amt));
            MODE_SHL: shift_step = d << amt;
            default:  shift_step = (d >> amt) | fill;
        endcase
    endfunction

    logic             adv;

    // Per-stage inputs: the ports for stage 0, the previous stage's register otherwise.
    logic [WIDTH-1:0] src_data  [SHW];
    logic [SHW-1:0]   src_shift [SHW];
    mode_e            src_mode  [SHW];
    logic [SHW-1:0]   src_sign;
    logic [SHW-1:0]   src_valid;

    logic [WIDTH-1:0] data_d    [SHW];
    logic [WIDTH-1:0] data_q    [SHW];

    // Control that must be carried forward. The last stage has no successor
    // and so keeps no copy.
    logic [SHW-1:0]   shift_q   [SHW-1];
    mode_e            mode_q    [SHW-1];
    logic [SHW-2:0]   sign_q;
    logic [SHW-1:0]   valid_q;
    logic             zero_q;

    // The pipeline advances whenever the output slot is empty or being drained.
    assign adv       = out_ready | ~valid_q[SHW-1];
    assign in_ready  = adv;
    assign out_valid = valid_q[SHW-1];
    assign out_data  = data_q[SHW-1];
    assign out_zero  = zero_q;

    // Route each stage's source beat. The ASR sign is captured here, from the
    // raw operand, and then carried with the beat.
    always_comb begin
        // NOTE: every element is assigned on every pass, so no latch can be inferred.
        src_data[0]  = in_data;
        src_shift[0] = in_shift;
        src_mode[0]  = mode_e'(in_mode);
        src_sign[0]  = in_data[WIDTH-1];
        src_valid[0] = in_valid;
        for (int k = 1; k < SHW; k++) begin
            src_data[k]  = data_q[k-1];
            src_shift[k] = shift_q[k-1];
            src_mode[k]  = mode_q[k-1];
            src_sign[k]  = sign_q[k-1];
            src_valid[k] = valid_q[k-1];
        end
    end

    // Stage k shifts by 2^k when bit k of the carried amount is set.
    always_comb begin
        for (int k = 0; k < SHW; k++) begin
            data_d[k] = src_shift[k][k]
                      ? shift_step(src_data[k], src_mode[k], src_sign[k], 1 << k)
                      : src_data[k];
        end
    end

    // Stage registers move in lockstep on adv and hold otherwise. The zero flag
    // is registered together with the final data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: datapath registers are reset as well, so out_data reads 0 out of reset.
            valid_q <= '0;
            zero_q  <= 1'b0;
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= '0;
            end
            for (int k = 0; k < SHW - 1; k++) begin
                shift_q[k] <= '0;
                mode_q[k]  <= MODE_ROL;
                sign_q[k]  <= 1'b0;
            end
        end else if (adv) begin
            valid_q <= src_valid;
            zero_q  <= (data_d[SHW-1] == '0);
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= data_d[k];
            end
            for (int k = 0; k < SHW - 1; k++) begin
                shift_q[k] <= src_shift[k];
                mode_q[k]  <= src_mode[k];
                sign_q[k]  <= src_sign[k];
            end
        end
    end

endmodule

// File: doc/barrel_shifter_pipe.md
Name: barrel_shifter_pipe

Overview:
- Parametrised, pipelined successor to the 8-bit combinational circular shifter.
- Generalises the data width and adds four shift modes: rotate left, rotate right, logical shift left and arithmetic shift right.
- Uses one register stage per shift-amount bit and a valid/ready handshake on both sides.
- Sits in the datapath library as the shared shift/rotate unit for the ALU and bit-manipulation blocks.

Parameters:
- WIDTH, 8, data width in bits. Must be a power of two, minimum 4.
- SHW, $clog2(WIDTH), shift-amount width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat present
- in_ready  output  1  block accepts input this cycle
- in_data  input  WIDTH  operand
- in_shift  input  SHW  shift amount, 0..WIDTH-1
- in_mode  input  2  00=ROL, 01=ROR, 10=SHL (zero fill), 11=ASR (sign fill)
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  shifted result
- out_zero  output  1  out_data == 0

Behaviour:
- Reset:
  - All stage valid bits, out_valid, out_data and out_zero clear to 0 immediately on rst high (asynchronous).
  - in_ready follows the formula below, so it reads 1 while in reset once out_valid = 0.
- Pipeline structure:
  - SHW stages, indexed k = 0..SHW-1. Stage k applies a shift of 2^k when bit k of the carried shift amount is set, using the carried mode.
  - Data, remaining shift bits, mode and a valid bit travel with each beat.
- Latency: exactly SHW cycles from an accepted input (in_valid & in_ready at edge N) to out_valid = 1 after edge N+SHW-1. For WIDTH=8 this is 3 cycles.
- Stall rule:
  - adv = out_ready | ~out_valid.
  - All stages advance together only when adv = 1; in_ready = adv.
  - When adv = 0, every stage register holds its value, and out_data/out_valid stay stable until accepted.
  - Bubbles are not collapsed.
- Throughput: one result per cycle while out_ready is held at 1.
- Fill rules:
  - ROL/ROR: bits wrap circularly.
  - SHL: vacated LSBs fill with 0.
  - ASR: vacated MSBs fill with the original in_data[WIDTH-1]. The sign is captured at stage 0 and carried with the beat.
- Shift amount 0 in any mode: out_data = in_data.
- out_zero is registered with out_data in the last stage, not computed combinationally from out_data.
- An input presented with in_valid = 0 is ignored: its stage valid bit is 0 and no result is produced.
- Reset mid-operation: all in-flight beats are discarded, with no partial result emitted after rst deasserts. The first beat accepted after reset appears SHW cycles later.
- in_mode, in_shift and in_data are sampled only on the accepting edge. Changes while in_ready = 0 have no effect.

Test Plan:
- WIDTH=8, back-to-back with out_ready=1, in_data=8'hAF, inputs issued in this order: (ROL,0), (ROL,1), (ROR,1), (SHL,3), (ASR,4).
  -> out_data sequence 8'hAF, 8'h5F, 8'hD7, 8'h78, 8'hFA on 5 consecutive cycles.
  -> first result 3 cycles after the first accept; out_zero = 0 throughout.
- Backpressure: drive out_ready=0 for 4 cycles while issuing the above stream.
  -> in_ready drops once out_valid = 1; out_data holds 8'hAF unchanged.
  -> release out_ready: all 5 results appear in order with no loss or duplicate.
- Zero flag and boundaries: 8'h80 SHL 1 -> 8'h00 with out_zero=1. 8'h80 ASR 7 -> 8'hFF. 8'h01 ROR 7 -> 8'h02.
- Reset mid-flight: accept 2 beats, assert rst for 1 cycle before they reach the output.
  -> out_valid=0 at once and neither result ever appears.
  -> next beat 8'h0F ROL 4 yields 8'hF0 after 3 cycles.
- WIDTH=16 instance (SHW=4): 16'h8001 ROR 15 -> 16'h0003 after 4 cycles; 16'h8000 ASR 15 -> 16'hFFFF.
- Gapped input: in_valid toggled 1,0,1 with out_ready=1.
  -> out_valid pattern 1,0,1 shifted by SHW cycles.
  -> no result emitted for the idle cycle.
